decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 37 +++
 rtl/decode_stage.sv | 157 +++++++++++++++
 tb/tb_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master = surrounding pipeline, slave = the decode stage.
interface decode_stage_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [INSTR_WIDTH-1:0]    in_instr;
    logic [DATA_WIDTH-1:0]     in_pc;
    logic                      out_valid;
    logic                      out_ready;
    logic [6:0]                out_alu_op;
    logic [2:0]                out_func3;
    logic [6:0]                out_func7;
    logic [DATA_WIDTH-1:0]     out_data1;
    logic [DATA_WIDTH-1:0]     out_data2;
    logic [DATA_WIDTH-1:0]     out_store_data;
    logic [DATA_WIDTH-1:0]     out_imm;
    logic [DATA_WIDTH-1:0]     out_pc;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic                      out_reg_write;
    logic                      out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_op, out_func3, out_func7, out_data1, out_data2,
               out_store_data, out_imm, out_pc, out_rd, out_reg_write, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu_op, out_func3, out_func7, out_data1, out_data2,
               out_store_data, out_imm, out_pc, out_rd, out_reg_write, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV64IM decode stage: field/immediate decode, operand select, scoreboard-based
// RAW hazard stall and a single registered output slot.
module decode_stage #(
    parameter int DATA_WIDTH     = 64,
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    decode_stage_if.slave             bus,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      flush
);
    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef struct packed {
        logic [6:0]                alu_op;
        logic [2:0]                func3;
        logic [6:0]                func7;
        logic [DATA_WIDTH-1:0]     data1;
        logic [DATA_WIDTH-1:0]     data2;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [DATA_WIDTH-1:0]     pc;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      illegal;
    } dec_op_t;

    logic [INSTR_WIDTH-1:0]    instr;
    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rd_idx;
    logic                      is_r, is_i, is_s, is_b, is_u, is_j, legal;
    logic [DATA_WIDTH-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    dec_op_t                   dec, out_q;
    logic                      out_valid_q;
    logic [NUM_REGS-1:0]       busy, busy_next;
    logic                      use_rs1, use_rs2, rs1_pend, rs2_pend, hazard, accept, leave;

    assign instr    = bus.in_instr;
    assign opcode   = instr[6:0];
    assign rd_idx   = instr[7 +: REG_ADDR_WIDTH];
    assign rs1_addr = instr[15 +: REG_ADDR_WIDTH];
    assign rs2_addr = instr[20 +: REG_ADDR_WIDTH];

    assign is_r  = (opcode == OP_REG) || (opcode == OP_REG32);
    assign is_i  = (opcode == OP_IMM) || (opcode == OP_IMM32) || (opcode == OP_LOAD) || (opcode == OP_JALR);
    assign is_s  = (opcode == OP_STORE);
    assign is_b  = (opcode == OP_BRANCH);
    assign is_u  = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign is_j  = (opcode == OP_JAL);
    assign legal = is_r || is_i || is_s || is_b || is_u || is_j;

    assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Illegal opcodes still travel down the pipe so execute can raise the trap.
    always_comb begin
        dec    = '0;
        dec.pc = bus.in_pc;
        if (!legal) begin
            dec.illegal = 1'b1;
        end else begin
            dec.alu_op     = opcode;
            dec.rd         = rd_idx;
            dec.store_data = rs2_data;
            if (is_i)      dec.imm = imm_i;
            else if (is_s) dec.imm = imm_s;
            else if (is_b) dec.imm = imm_b;
            else if (is_u) dec.imm = imm_u;
            else if (is_j) dec.imm = imm_j;
            if (is_r || is_i || is_s || is_b)
                dec.func3 = instr[14:12];
            if (is_r)
                dec.func7 = instr[31:25];
            else if (((opcode == OP_IMM) || (opcode == OP_IMM32)) && (instr[13:12] == 2'b01))
                dec.func7 = {1'b0, instr[30], 5'b0};
            dec.data1     = (is_j || (opcode == OP_JALR) || (opcode == OP_AUIPC)) ? bus.in_pc : rs1_data;
            dec.data2     = (is_r || is_b) ? rs2_data : dec.imm;
            dec.reg_write = !is_s && !is_b && (rd_idx != '0);
        end
    end

    // The op sitting in the output slot has not yet set its busy bit, so it is checked directly.
    assign use_rs1  = !(is_u || is_j);
    assign use_rs2  = is_r || is_s || is_b;
    assign rs1_pend = busy[rs1_addr] || (out_valid_q && out_q.reg_write && (out_q.rd == rs1_addr));
    assign rs2_pend = busy[rs2_addr] || (out_valid_q && out_q.reg_write && (out_q.rd == rs2_addr));
    assign hazard   = bus.in_valid && ((use_rs1 && (rs1_addr != '0) && rs1_pend) ||
                                       (use_rs2 && (rs2_addr != '0) && rs2_pend));

    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign leave        = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Clear is applied before set so a same-cycle retire/issue on one index leaves it busy.
    always_comb begin
        busy_next = busy;
        if (wb_valid)
            busy_next[wb_rd] = 1'b0;
        if (leave && out_q.reg_write)
            busy_next[out_q.rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_alu_op     = out_q.alu_op;
    assign bus.out_func3      = out_q.func3;
    assign bus.out_func7      = out_q.func7;
    assign bus.out_data1      = out_q.data1;
    assign bus.out_data2      = out_q.data2;
    assign bus.out_store_data = out_q.store_data;
    assign bus.out_imm        = out_q.imm;
    assign bus.out_pc         = out_q.pc;
    assign bus.out_rd         = out_q.rd;
    assign bus.out_reg_write  = out_q.reg_write;
    assign bus.out_illegal    = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Decode stage bench: directed cases with literal expectations, then random
// traffic checked every cycle against a behavioural decode/scoreboard model.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    logic [4:0]  rs1_addr, rs2_addr, wb_rd;
    logic [63:0] rs1_data, rs2_data;
    logic        wb_valid, flush;
    logic [63:0] rf [32];

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    decode_stage dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
    );

    typedef struct {
        logic [6:0]  alu_op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] d1, d2, sd, imm, pc;
        logic [4:0]  rd;
        logic        rw, ill;
    } dec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    dec_t m_held;
    bit   m_hv;
    bit   m_busy [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic byte fmt_of(input logic [6:0] op);
        case (op)
            7'h33, 7'h3B:               return "R";
            7'h13, 7'h1B, 7'h03, 7'h67: return "I";
            7'h23:                      return "S";
            7'h63:                      return "B";
            7'h37, 7'h17:               return "U";
            7'h6F:                      return "J";
            default:                    return "X";
        endcase
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
        dec_t d;
        longint v;
        byte f;
        logic [6:0] op;
        op = ins[6:0];
        f  = fmt_of(op);
        d  = '{default: '0};
        d.pc = pc;
        if (f == "X") begin
            d.ill = 1'b1;
            return d;
        end
        v = 0;
        if (f == "I") begin v = ins[31:20]; if (v >= 2048) v -= 4096; end
        if (f == "S") begin v = {ins[31:25], ins[11:7]}; if (v >= 2048) v -= 4096; end
        if (f == "B") begin v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; if (v >= 4096) v -= 8192; end
        if (f == "U") begin v = ins[31:12]; if (v >= 'h80000) v -= 'h100000; v = v * 4096; end
        if (f == "J") begin v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; if (v >= 'h100000) v -= 'h200000; end
        d.imm    = v;
        d.alu_op = op;
        d.f3     = (f == "R" || f == "I" || f == "S" || f == "B") ? ins[14:12] : 3'd0;
        if (f == "R")
            d.f7 = ins[31:25];
        else if ((op == 7'h13 || op == 7'h1B) && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))
            d.f7 = ins[30] ? 7'h20 : 7'h00;
        d.d1 = (op == 7'h6F || op == 7'h67 || op == 7'h17) ? pc : rf[ins[19:15]];
        d.d2 = (f == "R" || f == "B") ? rf[ins[24:20]] : d.imm;
        d.sd = rf[ins[24:20]];
        d.rd = ins[11:7];
        d.rw = !(f == "S" || f == "B") && (ins[11:7] != 5'd0);
        return d;
    endfunction

    function automatic bit pend(input logic [4:0] r);
        return m_busy[r] || (m_hv && m_held.rw && m_held.rd == r);
    endfunction

    // Checks all outputs against the model, then advances the model across one rising edge.
    task automatic cycle();
        bit hz, u1, u2, exp_rdy, acc;
        dec_t nxt;
        logic [6:0] op;
        logic [4:0] s1, s2;
        #1;
        op = bus.in_instr[6:0];
        s1 = bus.in_instr[19:15];
        s2 = bus.in_instr[24:20];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (fmt_of(op) == "R" || fmt_of(op) == "S" || fmt_of(op) == "B");
        hz = bus.in_valid && ((u1 && s1 != 0 && pend(s1)) || (u2 && s2 != 0 && pend(s2)));
        exp_rdy = (!m_hv || bus.out_ready) && !hz && !flush;
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
        chk("rs1_addr", {59'd0, rs1_addr}, {59'd0, s1});
        chk("rs2_addr", {59'd0, rs2_addr}, {59'd0, s2});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_hv});
        if (m_hv) begin
            chk("alu_op", {57'd0, bus.out_alu_op}, {57'd0, m_held.alu_op});
            chk("func3", {61'd0, bus.out_func3}, {61'd0, m_held.f3});
            chk("func7", {57'd0, bus.out_func7}, {57'd0, m_held.f7});
            chk("data1", bus.out_data1, m_held.d1);
            chk("data2", bus.out_data2, m_held.d2);
            chk("store_data", bus.out_store_data, m_held.sd);
            chk("imm", bus.out_imm, m_held.imm);
            chk("pc", bus.out_pc, m_held.pc);
            chk("rd", {59'd0, bus.out_rd}, {59'd0, m_held.rd});
            chk("reg_write", {63'd0, bus.out_reg_write}, {63'd0, m_held.rw});
            chk("illegal", {63'd0, bus.out_illegal}, {63'd0, m_held.ill});
        end
        acc = bus.in_valid && exp_rdy;
        nxt = ref_decode(bus.in_instr, bus.in_pc);
        @(posedge clk);
        if (wb_valid) m_busy[wb_rd] = 1'b0;
        if (m_hv && bus.out_ready && m_held.rw) m_busy[m_held.rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (flush)              m_hv = 1'b0;
        else if (acc)           begin m_held = nxt; m_hv = 1'b1; end
        else if (bus.out_ready) m_hv = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
        bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc = pc;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic retire(input logic [4:0] r);
        wb_valid = 1'b1; wb_rd = r;
        cycle();
        wb_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_hv = 1'b0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [14];
        logic [31:0] ins;
        ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h73, 7'h0F};
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 13)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        foreach (rf[i]) rf[i] = {$urandom, $urandom};
        rf[0] = 64'd0;
        bus.in_valid = 1'b0; bus.in_instr = 32'h0000_0013; bus.in_pc = 64'd0; bus.out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst data1", bus.out_data1, 64'd0);
        chk("rst imm", bus.out_imm, 64'd0);
        chk("rst rd", {59'd0, bus.out_rd}, 64'd0);
        reset = 1'b0;
        #1 chk("rst in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);

        // addi x1,x2,-5
        rf[2] = 64'd10;
        issue(32'hFFB1_0093, 64'h100);
        chk("addi valid", {63'd0, bus.out_valid}, 64'd1);
        chk("addi data1", bus.out_data1, 64'd10);
        chk("addi data2", bus.out_data2, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("addi func7", {57'd0, bus.out_func7}, 64'd0);
        chk("addi rd", {59'd0, bus.out_rd}, 64'd1);
        cycle();
        retire(1);

        // srai x3,x3,33
        issue(32'h4211_D193, 64'h104);
        chk("srai func3", {61'd0, bus.out_func3}, 64'd5);
        chk("srai func7", {57'd0, bus.out_func7}, 64'h20);
        chk("srai shamt", {58'd0, bus.out_data2[5:0]}, 64'd33);
        cycle();
        retire(3);

        // add x1,x2,x3 then dependent sub x4,x1,x5
        issue(32'h0031_00B3, 64'h200);
        bus.in_valid = 1'b1; bus.in_instr = 32'h4050_8233; bus.in_pc = 64'h204;
        for (int k = 0; k < 3; k++) begin
            #1 chk("raw stall", {63'd0, bus.in_ready}, 64'd0);
            cycle();
        end
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1 chk("raw stall wb", {63'd0, bus.in_ready}, 64'd0);
        cycle();
        wb_valid = 1'b0;
        #1 chk("raw release", {63'd0, bus.in_ready}, 64'd1);
        cycle();
        bus.in_valid = 1'b0;
        chk("sub rd", {59'd0, bus.out_rd}, 64'd4);
        chk("sub func7", {57'd0, bus.out_func7}, 64'h20);
        cycle();
        retire(4);

        // back-pressure hold and flush; busy[9] must survive the flush
        issue(32'h0010_0493, 64'h300);
        cycle();
        issue(32'h0070_0313, 64'h304);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0010_0393; bus.in_pc = 64'h308;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("hold data2", bus.out_data2, 64'd7);
            chk("hold rd", {59'd0, bus.out_rd}, 64'd6);
            cycle();
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.in_instr = 32'h0004_8533;
        #1 chk("flush out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush keeps busy", {63'd0, bus.in_ready}, 64'd0);
        cycle();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        retire(9);

        // jal x1,+8 then illegal opcode
        issue(32'h0080_00EF, 64'h1000);
        chk("jal data1", bus.out_data1, 64'h1000);
        chk("jal imm", bus.out_imm, 64'd8);
        chk("jal reg_write", {63'd0, bus.out_reg_write}, 64'd1);
        issue(32'h0000_007F, 64'h1004);
        chk("ill flag", {63'd0, bus.out_illegal}, 64'd1);
        chk("ill reg_write", {63'd0, bus.out_reg_write}, 64'd0);
        cycle();
        retire(1);

        // same-cycle retire and issue of x5: set wins
        issue(32'h0010_0293, 64'h400);
        retire(5);
        bus.in_valid = 1'b1; bus.in_instr = 32'h0002_85B3; bus.in_pc = 64'h404;
        #1 chk("set wins", {63'd0, bus.in_ready}, 64'd0);
        cycle();
        bus.in_valid = 1'b0;
        retire(5);

        // reset while an op is held
        issue(32'h0070_0313, 64'h500);
        bus.out_ready = 1'b0;
        #2 reset = 1'b1;
        #1 chk("mid rst valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid rst data2", bus.out_data2, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_instr  = rand_instr();
            bus.in_pc     = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            rf[$urandom_range(1, 31)] = {$urandom, $urandom};
            wb_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 8; k++) begin
                    int j;
                    j = $urandom_range(1, 7);
                    if (m_busy[j]) begin
                        wb_valid = 1'b1;
                        wb_rd = 5'(j);
                        break;
                    end
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
